// File: rtl/multi_click_detector.sv
// multi_click_detector
//   Groups debounced single-cycle button pulses into click gestures and emits
//   a one-cycle strobe with the click count when a gesture ends.
//   Optional feature macro: MULTI_CLICK_SATURATE_EN
//     defined   - clicks beyond MAX_CLICKS are absorbed; the gesture ends only
//                 after WINDOW quiet cycles and reports MAX_CLICKS.
//     undefined - the pulse that reaches MAX_CLICKS reports immediately.
module multi_click_detector #(
  parameter int WINDOW     = 8,
  parameter int MAX_CLICKS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  btn_pulse,
  output logic                                  click_valid,
  output logic [$clog2(MAX_CLICKS+1)-1:0]       click_count
);

  localparam int CNT_W = $clog2(MAX_CLICKS + 1);
  localparam int TMR_W = $clog2(WINDOW);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLICKS);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(WINDOW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // State, counters and registered outputs; reset discards any partial gesture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: a pulse always wins over the quiet-window timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    valid_d = 1'b0;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (btn_pulse) begin
          cnt_d   = CNT_ONE;
          timer_d = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (btn_pulse) begin
          timer_d = '0;
`ifdef MULTI_CLICK_SATURATE_EN
          // Extra clicks past the maximum only extend the gesture.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          // Reaching the maximum closes the gesture on this very edge.
          if (cnt_q == CNT_MAX - CNT_ONE) begin
            valid_d = 1'b1;
            count_d = CNT_MAX;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
        end else if (timer_q == TMR_END) begin
          valid_d = 1'b1;
          count_d = cnt_q;
          cnt_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign click_valid = valid_q;
  assign click_count = count_q;

endmodule

// File: tb/tb_multi_click_detector.sv
// Directed bench for multi_click_detector (WINDOW=8, MAX_CLICKS=3).
// Edge k is the k-th rising clock edge after reset release; outputs are
// sampled 1 time unit after each edge.
module tb_multi_click_detector;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             btn_pulse;
  logic             click_valid;
  logic [CNT_W-1:0] click_count;

  int checks   = 0;
  int failures = 0;

  logic [63:0]      got_vld;
  logic [CNT_W-1:0] got_cnt [0:63];

  multi_click_detector #(
    .WINDOW     (8),
    .MAX_CLICKS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .click_valid (click_valid),
    .click_count (click_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    btn_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive pulses on the edges flagged in pmask, optional rst on rst_edge,
  // and log the outputs seen after every edge 1..n.
  task automatic run_seq(input logic [63:0] pmask, input int rst_edge, input int n);
    do_reset();
    got_vld = '0;
    for (int k = 0; k < 64; k++) got_cnt[k] = '0;
    for (int k = 1; k <= n; k++) begin
      btn_pulse = pmask[k];
      rst       = (k == rst_edge);
      @(posedge clk);
      #1;
      got_vld[k] = click_valid;
      got_cnt[k] = click_count;
    end
    btn_pulse = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    run_seq(64'd1 << 10, 0, 20);
    checks++;
    if (got_vld !== (64'd1 << 18)) begin
      failures++;
      $display("FAIL reset_pre_strobes got=%h exp=%h", got_vld, 64'd1 << 18);
    end
    checks++;
    if (got_cnt[20] !== 2'd1) begin
      failures++;
      $display("FAIL reset_pre_hold got=%0d exp=1", got_cnt[20]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (click_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", click_valid);
    end
    checks++;
    if (click_count !== 2'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", click_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    run_seq(64'd1 << 10, 0, 30);
    checks++;
    if (got_vld !== (64'd1 << 18)) begin
      failures++;
      $display("FAIL single_strobes got=%h exp=%h", got_vld, 64'd1 << 18);
    end
    checks++;
    if (got_cnt[18] !== 2'd1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", got_cnt[18]);
    end
    checks++;
    if (got_cnt[30] !== 2'd1) begin
      failures++;
      $display("FAIL single_hold got=%0d exp=1", got_cnt[30]);
    end
  endtask

  task automatic test_double();
    run_seq((64'd1 << 10) | (64'd1 << 14), 0, 30);
    checks++;
    if (got_vld !== (64'd1 << 22)) begin
      failures++;
      $display("FAIL double_strobes got=%h exp=%h", got_vld, 64'd1 << 22);
    end
    checks++;
    if (got_cnt[22] !== 2'd2) begin
      failures++;
      $display("FAIL double_count got=%0d exp=2", got_cnt[22]);
    end
  endtask

  task automatic test_window_edge();
    run_seq((64'd1 << 10) | (64'd1 << 18), 0, 35);
    checks++;
    if (got_vld !== (64'd1 << 26)) begin
      failures++;
      $display("FAIL edge_strobes got=%h exp=%h", got_vld, 64'd1 << 26);
    end
    checks++;
    if (got_cnt[26] !== 2'd2) begin
      failures++;
      $display("FAIL edge_count got=%0d exp=2", got_cnt[26]);
    end
  endtask

  task automatic test_max_clicks();
    run_seq((64'd1 << 10) | (64'd1 << 12) | (64'd1 << 14) | (64'd1 << 16), 0, 35);
`ifdef MULTI_CLICK_SATURATE_EN
    checks++;
    if (got_vld !== (64'd1 << 24)) begin
      failures++;
      $display("FAIL max_strobes got=%h exp=%h", got_vld, 64'd1 << 24);
    end
    checks++;
    if (got_cnt[24] !== 2'd3) begin
      failures++;
      $display("FAIL max_count got=%0d exp=3", got_cnt[24]);
    end
`else
    checks++;
    if (got_vld !== ((64'd1 << 14) | (64'd1 << 24))) begin
      failures++;
      $display("FAIL max_strobes got=%h exp=%h", got_vld, (64'd1 << 14) | (64'd1 << 24));
    end
    checks++;
    if (got_cnt[14] !== 2'd3) begin
      failures++;
      $display("FAIL max_count_first got=%0d exp=3", got_cnt[14]);
    end
    checks++;
    if (got_cnt[24] !== 2'd1) begin
      failures++;
      $display("FAIL max_count_second got=%0d exp=1", got_cnt[24]);
    end
`endif
  endtask

  task automatic test_mid_reset();
    run_seq((64'd1 << 10) | (64'd1 << 12) | (64'd1 << 20), 14, 35);
    checks++;
    if (got_vld !== (64'd1 << 28)) begin
      failures++;
      $display("FAIL midrst_strobes got=%h exp=%h", got_vld, 64'd1 << 28);
    end
    checks++;
    if (got_cnt[28] !== 2'd1) begin
      failures++;
      $display("FAIL midrst_count got=%0d exp=1", got_cnt[28]);
    end
  endtask

  task automatic test_after_report();
    run_seq((64'd1 << 10) | (64'd1 << 19), 0, 35);
    checks++;
    if (got_vld !== ((64'd1 << 18) | (64'd1 << 27))) begin
      failures++;
      $display("FAIL after_strobes got=%h exp=%h", got_vld, (64'd1 << 18) | (64'd1 << 27));
    end
    checks++;
    if (got_cnt[18] !== 2'd1) begin
      failures++;
      $display("FAIL after_count_first got=%0d exp=1", got_cnt[18]);
    end
    checks++;
    if (got_cnt[27] !== 2'd1) begin
      failures++;
      $display("FAIL after_count_second got=%0d exp=1", got_cnt[27]);
    end
  endtask

  task automatic test_back_to_back();
    run_seq((64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 13) | (64'd1 << 14), 0, 30);
`ifdef MULTI_CLICK_SATURATE_EN
    checks++;
    if (got_vld !== (64'd1 << 22)) begin
      failures++;
      $display("FAIL b2b_strobes got=%h exp=%h", got_vld, 64'd1 << 22);
    end
    checks++;
    if (got_cnt[22] !== 2'd3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", got_cnt[22]);
    end
`else
    checks++;
    if (got_vld !== ((64'd1 << 12) | (64'd1 << 22))) begin
      failures++;
      $display("FAIL b2b_strobes got=%h exp=%h", got_vld, (64'd1 << 12) | (64'd1 << 22));
    end
    checks++;
    if (got_cnt[12] !== 2'd3) begin
      failures++;
      $display("FAIL b2b_count_first got=%0d exp=3", got_cnt[12]);
    end
    checks++;
    if (got_cnt[22] !== 2'd2) begin
      failures++;
      $display("FAIL b2b_count_second got=%0d exp=2", got_cnt[22]);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    btn_pulse = 1'b0;
    test_reset();
    test_single();
    test_double();
    test_window_edge();
    test_max_clicks();
    test_mid_reset();
    test_after_report();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
